// File: rtl/uart_sample_framer.sv
// Byte-to-sample framer: hunts for a sync byte, packs little-endian 16-bit samples
// into a 2-entry stream FIFO, and reports each frame as good (checksum) or bad.
module uart_sample_framer #(
  parameter int unsigned SAMPLE_COUNT   = 64,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [15:0] sample_data_o,
  output logic        sample_valid_o,
  input  logic        sample_ready_i,
  output logic        sample_last_o,
  output logic        frame_ok_o,
  output logic        frame_err_o,
  output logic        busy_o
);

  localparam int unsigned IW = (SAMPLE_COUNT > 1) ? $clog2(SAMPLE_COUNT) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLE_COUNT - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    CSUM = 2'd3
  } state_e;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_e        state_q, state_d;
  logic [7:0]    lo_q, lo_d;
  logic [7:0]    csum_q, csum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;

  logic [16:0]   mem_q [2];
  logic [1:0]    count_q, count_d;
  logic          rd_ptr_q, wr_ptr_q;
  logic          push_s, pop_s, full_s;
  logic [16:0]   push_word_s;

  assign full_s         = (count_q == 2'd2);
  assign sample_valid_o = (count_q != 2'd0);
  assign pop_s          = sample_valid_o & sample_ready_i;
  assign sample_data_o  = mem_q[rd_ptr_q][15:0];
  assign sample_last_o  = sample_valid_o & mem_q[rd_ptr_q][16];
  assign frame_ok_o     = ok_q;
  assign frame_err_o    = err_q;
  assign busy_o         = (state_q != HUNT);

  // Framer next-state: timeout handling first, byte handling may override on a strobe
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    csum_d      = csum_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    push_s      = 1'b0;
    push_word_s = 17'd0;

    if (rx_valid_i) begin
      tmo_d = {TW{1'b0}};
    end else if (state_q != HUNT) begin
      if (tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        state_d = HUNT;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = tmo_q;
    end

    case (state_q)
      HUNT: begin
        if (rx_valid_i && (rx_data_i == SYNC_BYTE)) begin
          csum_d  = 8'd0;
          idx_d   = {IW{1'b0}};
          state_d = LO;
        end else begin
          state_d = HUNT;
        end
      end
      LO: begin
        if (rx_valid_i) begin
          lo_d    = rx_data_i;
          csum_d  = csum_add(csum_q, rx_data_i);
          state_d = HI;
        end else begin
          lo_d = lo_q;
        end
      end
      HI: begin
        if (rx_valid_i) begin
          csum_d = csum_add(csum_q, rx_data_i);
          // Full with no pop this cycle: nowhere to put the sample, abort the frame
          if (full_s && !pop_s) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            push_s      = 1'b1;
            push_word_s = {(idx_q == LAST_IDX), rx_data_i, lo_q};
            if (idx_q == LAST_IDX) begin
              state_d = CSUM;
            end else begin
              idx_d   = idx_q + IW'(1);
              state_d = LO;
            end
          end
        end else begin
          csum_d = csum_q;
        end
      end
      CSUM: begin
        if (rx_valid_i) begin
          if (rx_data_i == csum_q) begin
            ok_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = HUNT;
        end else begin
          csum_d = csum_q;
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase
  end

  // Framer state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= HUNT;
      lo_q    <= 8'd0;
      csum_q  <= 8'd0;
      idx_q   <= {IW{1'b0}};
      tmo_q   <= {TW{1'b0}};
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      csum_q  <= csum_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  // FIFO occupancy next-state
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; a push while full always coincides with a pop of the head it overwrites
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= 17'd0;
      mem_q[1] <= 17'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= push_word_s;
        wr_ptr_q        <= ~wr_ptr_q;
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_uart_sample_framer.sv
// Directed bench for uart_sample_framer with SAMPLE_COUNT=4 and TIMEOUT_CYCLES=100.
module tb_uart_sample_framer;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        sample_last;
  logic        frame_ok;
  logic        frame_err;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];
  logic [7:0]  tx_q[$];

  uart_sample_framer #(
    .SAMPLE_COUNT  (4),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rx_data_i     (rx_data),
    .rx_valid_i    (rx_valid),
    .sample_data_o (sample_data),
    .sample_valid_o(sample_valid),
    .sample_ready_i(sample_ready),
    .sample_last_o (sample_last),
    .frame_ok_o    (frame_ok),
    .frame_err_o   (frame_err),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record accepted samples and frame pulses mid-cycle
  always @(negedge clk) begin
    if (sample_valid && sample_ready) got_q.push_back({sample_last, sample_data});
    if (frame_ok) ok_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_list(input int gap);
    for (int i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i]);
      idle(gap);
    end
  endtask

  task automatic clear_log();
    got_q.delete();
    ok_cnt  = 0;
    err_cnt = 0;
  endtask

  task automatic check_samples(input string tag);
    check_val({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check_val($sformatf("%s_s%0d", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    sample_ready = 1'b1;
    idle(3);
    check_val("rst_valid", sample_valid, 1'b0);
    check_val("rst_data", sample_data, 16'h0000);
    check_val("rst_last", sample_last, 1'b0);
    check_val("rst_ok", frame_ok, 1'b0);
    check_val("rst_err", frame_err, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    rst = 1'b0;
    idle(2);

    // Good frame, bytes spaced by one idle cycle
    clear_log();
    send_byte(8'hA5);
    check_val("t1_busy_rise", busy, 1'b1);
    idle(1);
    tx_q = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h04};
    send_list(1);
    idle(3);
    exp_q = '{17'h00001, 17'h00002, 17'h00003, 17'h10004};
    check_samples("t1");
    check_val("t1_ok", ok_cnt, 1);
    check_val("t1_err", err_cnt, 0);
    check_val("t1_busy", busy, 1'b0);

    // Bad checksum
    clear_log();
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05};
    send_list(2);
    idle(3);
    check_samples("t2");
    check_val("t2_ok", ok_cnt, 0);
    check_val("t2_err", err_cnt, 1);

    // Garbage then back-to-back frame containing a sync value as data
    clear_log();
    tx_q = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'hA5, 8'h00, 8'h01, 8'h00,
             8'h02, 8'h00, 8'h03, 8'h00, 8'hA5};
    send_list(0);
    idle(3);
    exp_q = '{17'h000A5, 17'h00001, 17'h00002, 17'h10003};
    check_samples("t3");
    check_val("t3_ok", ok_cnt, 1);
    check_val("t3_err", err_cnt, 0);

    // Timeout: 100 idle cycles after the last strobe
    clear_log();
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h02};
    send_list(0);
    idle(99);
    check_val("t4_err_early", frame_err, 1'b0);
    check_val("t4_busy_early", busy, 1'b1);
    idle(1);
    check_val("t4_err_pulse", frame_err, 1'b1);
    check_val("t4_busy_fall", busy, 1'b0);
    idle(1);
    check_val("t4_err_once", frame_err, 1'b0);
    check_val("t4_err_cnt", err_cnt, 1);
    clear_log();
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h04};
    send_list(1);
    idle(3);
    exp_q = '{17'h00001, 17'h00002, 17'h00003, 17'h10004};
    check_samples("t4b");
    check_val("t4b_ok", ok_cnt, 1);
    check_val("t4b_err", err_cnt, 0);

    // Overflow with ready held low
    clear_log();
    sample_ready = 1'b0;
    tx_q = '{8'hA5, 8'h01, 8'h00};
    send_list(0);
    check_val("t5_valid_lat", sample_valid, 1'b1);
    check_val("t5_head", sample_data, 16'h0001);
    tx_q = '{8'h02, 8'h00, 8'h03};
    send_list(0);
    check_val("t5_head_stable", sample_data, 16'h0001);
    send_byte(8'h00);
    check_val("t5_ovf_err", frame_err, 1'b1);
    check_val("t5_ovf_busy", busy, 1'b0);
    tx_q = '{8'h04, 8'h00, 8'h04};
    send_list(0);
    sample_ready = 1'b1;
    idle(4);
    exp_q = '{17'h00001, 17'h00002};
    check_samples("t5");
    check_val("t5_err", err_cnt, 1);
    check_val("t5_ok", ok_cnt, 0);
    check_val("t5_drained", sample_valid, 1'b0);

    // Reset mid-frame with one sample queued
    clear_log();
    sample_ready = 1'b0;
    tx_q = '{8'hA5, 8'h01, 8'h00};
    send_list(0);
    check_val("t6_queued", sample_valid, 1'b1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_val("t6_valid", sample_valid, 1'b0);
    check_val("t6_busy", busy, 1'b0);
    check_val("t6_ok", frame_ok, 1'b0);
    check_val("t6_err", frame_err, 1'b0);
    idle(2);
    check_val("t6_no_pulses", ok_cnt + err_cnt, 0);
    sample_ready = 1'b1;
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h04};
    send_list(0);
    idle(3);
    exp_q = '{17'h00001, 17'h00002, 17'h00003, 17'h10004};
    check_samples("t6b");
    check_val("t6b_ok", ok_cnt, 1);
    check_val("t6b_err", err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
